// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares a single-port sync RAM between the CPU load/store path and a host port.
// Optional host_lock port (freezes the CPU) enabled by defining DMEM_ARB_HOST_LOCK_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_W        = 11,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_HOST_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
`ifdef DMEM_ARB_HOST_LOCK_EN
  input  logic              host_lock,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned WAIT_W = 4;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_HOST_WAIT);

  typedef enum logic [1:0] {IDLE, CPU_RD, HOST_RD} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] host_wait, host_wait_nxt;
  logic              lock_active;
  logic              host_win, cpu_win;

`ifdef DMEM_ARB_HOST_LOCK_EN
  assign lock_active = host_lock;
`else
  assign lock_active = 1'b0;
`endif

  // State and host starvation counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      host_wait <= '0;
    end else begin
      state     <= state_nxt;
      host_wait <= host_wait_nxt;
    end
  end

  // Arbitration, memory drive and completion signalling
  always_comb begin
    state_nxt   = state;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    host_gnt    = 1'b0;
    cpu_rvalid  = 1'b0;
    cpu_rdata   = '0;
    host_rvalid = 1'b0;
    host_rdata  = '0;
    cpu_stall   = cpu_req;
    host_win    = 1'b0;
    cpu_win     = 1'b0;
    if (rst) begin
      unique case (state)
        IDLE: begin
          host_win = host_req && (!cpu_req || lock_active || (host_wait == WAIT_MAX));
          cpu_win  = !host_win && cpu_req && !lock_active;
          if (host_win) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            host_gnt  = 1'b1;
            if (!host_we) state_nxt = HOST_RD;
          end else if (cpu_win) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            cpu_stall = !cpu_we;
            if (!cpu_we) state_nxt = CPU_RD;
          end
        end
        CPU_RD: begin
          cpu_rvalid = 1'b1;
          cpu_rdata  = mem_rdata;
          cpu_stall  = 1'b0;
          state_nxt  = IDLE;
        end
        HOST_RD: begin
          host_rvalid = 1'b1;
          host_rdata  = mem_rdata;
          state_nxt   = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Wait counter saturates so the host is forced through after MAX_HOST_WAIT losses
  always_comb begin
    host_wait_nxt = host_wait;
    if (host_gnt || !host_req) host_wait_nxt = '0;
    else if (host_wait != WAIT_MAX) host_wait_nxt = host_wait + WAIT_W'(1);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we, host_req, host_we;
  logic [ADDR_W-1:0] cpu_addr, host_addr;
  logic [DATA_W-1:0] cpu_wdata, host_wdata;
  logic [DATA_W-1:0] cpu_rdata, host_rdata;
  logic              cpu_rvalid, cpu_stall, host_gnt, host_rvalid;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef DMEM_ARB_HOST_LOCK_EN
  logic              host_lock;
`endif

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOST_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
`ifdef DMEM_ARB_HOST_LOCK_EN
    .host_lock(host_lock),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port RAM model
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    mem_rdata = '0;
`ifdef DMEM_ARB_HOST_LOCK_EN
    host_lock = 1'b0;
`endif

    // Reset state
    next_cycle(); settle();
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_host_rvalid", 32'(host_rvalid), 32'd0);
    next_cycle(); rst = 1'b1;

    // Idle: inputs present but no request -> memory bus zeroed
    cpu_addr = 11'h3AA; cpu_wdata = 32'hCAFEF00D; settle();
    check("idle_mem_en", 32'(mem_en), 32'd0);
    check("idle_mem_addr", 32'(mem_addr), 32'd0);
    check("idle_mem_wdata", mem_wdata, 32'd0);

    // CPU write 0x005 then read it back
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h005; cpu_wdata = 32'hDEADBEEF; settle();
    check("cw_mem_en", 32'(mem_en), 32'd1);
    check("cw_mem_we", 32'(mem_we), 32'd1);
    check("cw_mem_addr", 32'(mem_addr), 32'h005);
    check("cw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("cw_stall", 32'(cpu_stall), 32'd0);
    next_cycle(); cpu_we = 1'b0; settle();
    check("cr_issue_stall", 32'(cpu_stall), 32'd1);
    check("cr_issue_we", 32'(mem_we), 32'd0);
    next_cycle(); settle();
    check("cr_rvalid", 32'(cpu_rvalid), 32'd1);
    check("cr_rdata", cpu_rdata, 32'hDEADBEEF);
    check("cr_stall", 32'(cpu_stall), 32'd0);
    check("cr_no_issue", 32'(mem_en), 32'd0);
    next_cycle(); cpu_req = 1'b0; settle();
    check("cr_rvalid_drop", 32'(cpu_rvalid), 32'd0);
    check("cr_rdata_zero", cpu_rdata, 32'd0);

    // Host write then read of 0x7FF
    next_cycle();
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'h7FF; host_wdata = 32'h12345678; settle();
    check("hw_gnt", 32'(host_gnt), 32'd1);
    check("hw_mem_addr", 32'(mem_addr), 32'h7FF);
    check("hw_mem_we", 32'(mem_we), 32'd1);
    next_cycle(); host_we = 1'b0; settle();
    check("hr_gnt", 32'(host_gnt), 32'd1);
    check("hr_mem_we", 32'(mem_we), 32'd0);
    next_cycle(); host_req = 1'b0; settle();
    check("hr_rvalid", 32'(host_rvalid), 32'd1);
    check("hr_rdata", host_rdata, 32'h12345678);
    check("hr_no_issue", 32'(mem_en), 32'd0);
    check("hr_gnt_low", 32'(host_gnt), 32'd0);

    // Contention: CPU writes win 4 cycles, then host is forced through
    next_cycle();
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'h100; host_wdata = 32'h0000AAAA;
    cpu_req = 1'b1; cpu_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 11'(11'h200 + i); cpu_wdata = 32'(i); settle();
      check("ct_cpu_gnt", 32'(host_gnt), 32'd0);
      check("ct_cpu_addr", 32'(mem_addr), 32'(11'h200 + i));
      check("ct_cpu_stall", 32'(cpu_stall), 32'd0);
      next_cycle();
    end
    cpu_addr = 11'h204; settle();
    check("ct_host_gnt", 32'(host_gnt), 32'd1);
    check("ct_host_addr", 32'(mem_addr), 32'h100);
    check("ct_host_stall", 32'(cpu_stall), 32'd1);
    next_cycle(); host_req = 1'b0; settle();
    check("ct_resume_gnt", 32'(host_gnt), 32'd0);
    check("ct_resume_addr", 32'(mem_addr), 32'h204);
    check("ct_resume_stall", 32'(cpu_stall), 32'd0);
    next_cycle(); cpu_req = 1'b0;

    // Host read blocks CPU read raised during HOST_RD
    next_cycle();
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h100; settle();
    check("hb_gnt", 32'(host_gnt), 32'd1);
    next_cycle();
    host_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h005; settle();
    check("hb_host_rvalid", 32'(host_rvalid), 32'd1);
    check("hb_host_rdata", host_rdata, 32'h0000AAAA);
    check("hb_stall_hostrd", 32'(cpu_stall), 32'd1);
    check("hb_no_issue", 32'(mem_en), 32'd0);
    next_cycle(); settle();
    check("hb_cpu_issue", 32'(mem_en), 32'd1);
    check("hb_cpu_addr", 32'(mem_addr), 32'h005);
    check("hb_stall_issue", 32'(cpu_stall), 32'd1);
    next_cycle(); settle();
    check("hb_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check("hb_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    next_cycle(); cpu_req = 1'b0;

    // Reset asserted in HOST_RD with a CPU read pending
    next_cycle();
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h005; settle();
    check("rs_gnt", 32'(host_gnt), 32'd1);
    next_cycle();
    host_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h7FF; rst = 1'b0; settle();
    check("rs_host_rvalid", 32'(host_rvalid), 32'd0);
    check("rs_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rs_mem_en", 32'(mem_en), 32'd0);
    check("rs_stall", 32'(cpu_stall), 32'd1);
    next_cycle(); rst = 1'b1; settle();
    check("rs_cpu_issue", 32'(mem_en), 32'd1);
    check("rs_cpu_addr", 32'(mem_addr), 32'h7FF);
    check("rs_host_rvalid2", 32'(host_rvalid), 32'd0);
    next_cycle(); settle();
    check("rs_cpu_rvalid2", 32'(cpu_rvalid), 32'd1);
    check("rs_cpu_rdata", cpu_rdata, 32'h12345678);
    next_cycle(); cpu_req = 1'b0;

`ifdef DMEM_ARB_HOST_LOCK_EN
    // Lock: CPU frozen for 10 cycles with no host traffic
    next_cycle();
    host_lock = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h010;
    for (int i = 0; i < 10; i++) begin
      settle();
      check("lk_mem_en", 32'(mem_en), 32'd0);
      check("lk_stall", 32'(cpu_stall), 32'd1);
      next_cycle();
    end
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'h011; settle();
    check("lk_host_gnt", 32'(host_gnt), 32'd1);
    next_cycle(); host_req = 1'b0; cpu_req = 1'b0; host_lock = 1'b0;
`endif

    next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory (1-cycle read latency) between the processor load/store path and a host loader/debug port.
- Sits between the processor's mem_read/mem_write/alu_out/read_data_2 signals and the data memory instance.
- Drives a stall back to the processor so the PC and register file hold while the processor's access is pending.
- Fixed CPU priority, with a bounded-wait guarantee for the host.

Parameters:
- ADDR_W, 11, memory word-address width
- DATA_W, 32, data width
- MAX_HOST_WAIT, 4, maximum consecutive cycles the host may wait while the CPU wins arbitration (valid range 1..15)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- cpu_req  in  1  CPU access request; held until the access completes
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data; valid only when cpu_rvalid=1, else 0
- cpu_rvalid  out  1  CPU read-data-valid pulse
- cpu_stall  out  1  hold the processor this cycle
- host_req  in  1  host access request; held until host_gnt
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host word address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host access issued this cycle
- host_rdata  out  DATA_W  read data; valid only when host_rvalid=1, else 0
- host_rvalid  out  1  host read-data-valid pulse
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read issue

Behaviour:
- State registers: state, one of IDLE, CPU_RD, HOST_RD; host_wait counter, 4 bits.
- Reset (rst=0, asynchronous): state=IDLE, host_wait=0, cpu_rvalid=0, host_rvalid=0.
  - All combinational outputs then evaluate to 0, except cpu_stall, which equals cpu_req.
  - A read in flight is discarded; no rvalid pulse follows reset.
- Issue decision (combinational, in IDLE only):
  - Host wins if host_req=1 and (cpu_req=0 or host_wait==MAX_HOST_WAIT).
  - Otherwise the CPU wins if cpu_req=1.
  - Otherwise no issue: mem_en=0, and mem_we/mem_addr/mem_wdata are driven to 0.
- Winner drives mem_en=1, mem_we, mem_addr and mem_wdata from its own inputs.
- host_gnt=1 exactly in the cycle a host access issues.
- CPU write: completes in its issue cycle; cpu_stall=0; state stays IDLE.
- CPU read:
  - Issue cycle: cpu_stall=1; next state CPU_RD.
  - CPU_RD cycle: cpu_rvalid=1, cpu_rdata=mem_rdata, cpu_stall=0, no memory issue; next state IDLE.
- Host write: completes in the issue cycle; state stays IDLE.
- Host read:
  - Issue cycle: next state HOST_RD.
  - HOST_RD cycle: host_rvalid=1, host_rdata=mem_rdata, no issue; next state IDLE.
  - cpu_stall=cpu_req throughout HOST_RD.
- cpu_stall=1 whenever cpu_req=1 and the CPU is not completing this cycle. This includes losing arbitration to the host and being in HOST_RD.
- Read latency: rvalid occurs exactly 1 cycle after issue. Peak throughput is one write per cycle, or one read every 2 cycles.
- host_wait:
  - Cleared when host_gnt=1 or host_req=0.
  - Otherwise incremented each cycle, saturating at MAX_HOST_WAIT.
  - This guarantees a grant within MAX_HOST_WAIT+2 cycles of host_req rising.
- Simultaneous cpu_req and host_req with host_wait<MAX_HOST_WAIT: the CPU wins.
- A request raised during CPU_RD or HOST_RD is considered in the next IDLE cycle.

Optional Feature:
- Macro: DMEM_ARB_HOST_LOCK_EN.
- When defined: adds input port host_lock (1 bit).
  - While host_lock=1, the CPU is never issued and cpu_stall=cpu_req.
  - The host is issued whenever host_req=1 in IDLE.
  - A CPU_RD already in progress still completes.
  - Used to freeze the processor during program/data loading.
- When undefined: the port does not exist and arbitration is exactly as in Behaviour.

Test Plan:
- Reset: rst=0 mid HOST_RD, with cpu_req=1 → host_rvalid=0, cpu_rvalid=0, mem_en=0, cpu_stall=1. After release, the first IDLE cycle issues the CPU access.
- CPU write then read: write addr 0x005 with 0xDEADBEEF, then a read of 0x005 → write cycle has cpu_stall=0; read issue has cpu_stall=1; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF.
- Host-only read: host_req read of 0x7FF holding 0x12345678 → host_gnt in cycle 0, host_rvalid=1 with 0x12345678 in cycle 1.
- Contention: cpu_req (back-to-back writes) and host_req held from cycle 0, MAX_HOST_WAIT=4 → CPU issued cycles 0-3, host_gnt in cycle 4 with cpu_stall=1, CPU resumes in cycle 5.
- Host read blocks CPU: host read issued, cpu_req read raised in HOST_RD → cpu_stall=1 through HOST_RD and the CPU issue cycle; cpu_rvalid is 2 cycles after the host issue +1.
- Lock (DMEM_ARB_HOST_LOCK_EN): host_lock=1, cpu_req=1 for 10 cycles, no host_req → mem_en=0 and cpu_stall=1 all 10 cycles.
